// File: rtl/preempt_rr_arbiter.sv
// Single-resource arbiter: requester 0 preempts, requesters 1..N-1 share round-robin,
// every tenure is bounded by a watchdog; preemptions and timeouts are counted.
module preempt_rr_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic [1:0]           state,
  output logic                 preempted,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     nb_preempts,
  output logic [CNT_W-1:0]     nb_timeouts
);

  localparam int unsigned IdW   = $clog2(N);
  localparam int unsigned HoldW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle = 2'd0, StOwnLo = 2'd1, StOwnHi = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       grant_q, grant_d;
  logic [IdW-1:0]     id_q, id_d;
  logic [IdW-1:0]     saved_id_q, saved_id_d;
  logic               saved_vld_q, saved_vld_d;
  logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic               pre_q, pre_d;
  logic               to_q, to_d;
  logic [CNT_W-1:0]   nb_pre_q, nb_pre_d;
  logic [CNT_W-1:0]   nb_to_q, nb_to_d;

  logic               done_own, at_limit, rr_found;
  logic [IdW-1:0]     rr_id;
  int unsigned        rr_cand;

  assign done_own = (state_q != StIdle) && done[id_q];
  assign at_limit = (hold_q == HoldW'(TIMEOUT - 1));

  // Round-robin search over 1..N-1 starting just after rr_ptr, wrapping N-1 -> 1.
  always_comb begin
    rr_found = 1'b0;
    rr_id    = '0;
    rr_cand  = 0;
    for (int unsigned i = 1; i < N; i++) begin
      rr_cand = ((int'(rr_ptr_q) - 1 + i) % (N - 1)) + 1;
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_id    = IdW'(rr_cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    saved_id_d  = saved_id_q;
    saved_vld_d = saved_vld_q;
    rr_ptr_d    = rr_ptr_q;
    hold_d      = hold_q;
    pre_d       = 1'b0;
    to_d        = 1'b0;
    nb_pre_d    = nb_pre_q;
    nb_to_d     = nb_to_q;

    if (state_q == StOwnLo && req[0] && !done_own) begin
      // Preemption takes precedence over a coincident timeout.
      saved_id_d  = id_q;
      saved_vld_d = 1'b1;
      id_d        = '0;
      state_d     = StOwnHi;
      hold_d      = '0;
      pre_d       = 1'b1;
      nb_pre_d    = (&nb_pre_q) ? nb_pre_q : nb_pre_q + 1'b1;
    end else if (state_q == StIdle || done_own || at_limit) begin
      if (state_q != StIdle && !done_own) begin
        to_d    = 1'b1;
        nb_to_d = (&nb_to_q) ? nb_to_q : nb_to_q + 1'b1;
      end
      hold_d = '0;
      if (req[0]) begin
        id_d    = '0;
        state_d = StOwnHi;
      end else if (saved_vld_q && req[saved_id_q]) begin
        id_d        = saved_id_q;
        saved_vld_d = 1'b0;
        state_d     = StOwnLo;
      end else begin
        saved_vld_d = 1'b0;
        if (rr_found) begin
          id_d     = rr_id;
          rr_ptr_d = rr_id;
          state_d  = StOwnLo;
        end else begin
          id_d    = '0;
          state_d = StIdle;
        end
      end
    end else begin
      hold_d = hold_q + 1'b1;
    end

    grant_d = '0;
    if (state_d != StIdle) grant_d[id_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      id_q        <= '0;
      saved_id_q  <= '0;
      saved_vld_q <= 1'b0;
      rr_ptr_q    <= IdW'(N - 1);
      hold_q      <= '0;
      pre_q       <= 1'b0;
      to_q        <= 1'b0;
      nb_pre_q    <= '0;
      nb_to_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      id_q        <= id_d;
      saved_id_q  <= saved_id_d;
      saved_vld_q <= saved_vld_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_q      <= hold_d;
      pre_q       <= pre_d;
      to_q        <= to_d;
      nb_pre_q    <= nb_pre_d;
      nb_to_q     <= nb_to_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = id_q;
  assign state       = state_q;
  assign preempted   = pre_q;
  assign timeout_err = to_q;
  assign nb_preempts = nb_pre_q;
  assign nb_timeouts = nb_to_q;

endmodule

// File: tb/tb_preempt_rr_arbiter.sv
// Scoreboard bench for preempt_rr_arbiter (N=4, TIMEOUT=16, CNT_W=2 so saturation is reachable).
module tb_preempt_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] done = '0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic [1:0] state;
  logic       preempted;
  logic       timeout_err;
  logic [1:0] nb_preempts;
  logic [1:0] nb_timeouts;

  int checks = 0;
  int failures = 0;

  logic [1:0] exp_pre = '0;
  logic [1:0] exp_to = '0;

  typedef struct {
    string       name;
    logic [13:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [13:0] obs;

  preempt_rr_arbiter #(
    .N(4),
    .TIMEOUT(16),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .done(done),
    .grant(grant),
    .grant_id(grant_id),
    .state(state),
    .preempted(preempted),
    .timeout_err(timeout_err),
    .nb_preempts(nb_preempts),
    .nb_timeouts(nb_timeouts)
  );

  always #5 clk = ~clk;

  assign obs = {grant, grant_id, state, preempted, timeout_err, nb_preempts, nb_timeouts};

  // Expected output vector built from the bench's own counter model.
  function automatic logic [13:0] pk(logic [3:0] g, logic [1:0] st, logic p, logic t);
    logic [1:0] id;
    id = g[1] ? 2'd1 : g[2] ? 2'd2 : g[3] ? 2'd3 : 2'd0;
    return {g, id, st, p, t, exp_pre, exp_to};
  endfunction

  function automatic logic [1:0] sat_inc(logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    sb.push_back('{"reset_hold", pk(4'b0000, 2'd0, 1'b0, 1'b0)});
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
    end
    reset = 1'b0;
    sb.push_back('{"reset_first_grant", pk(4'b0001, 2'd2, 1'b0, 1'b0)});
    sb.push_back('{"reset_release_idle", pk(4'b0000, 2'd0, 1'b0, 1'b0)});
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
    end
    req  = '0;
    done = 4'b0001;
    tick();
    done = '0;
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [7];
    seq = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0010};
    req = 4'b1110;
    for (int i = 0; i < 7; i++) sb.push_back('{"rr_seq", pk(seq[i], 2'd1, 1'b0, 1'b0)});
    for (int i = 0; i < 7; i++) begin
      tick();
      done = '0;
      e = sb.pop_front();
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL %s[%0d]: got %h expected %h", e.name, i, obs, e.v);
      end
      if (i % 2 == 1) done = e.v[13:10];
    end
    req  = '0;
    done = 4'b0010;
    sb.push_back('{"rr_release", pk(4'b0000, 2'd0, 1'b0, 1'b0)});
    tick();
    done = '0;
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
    end
  endtask

  task automatic test_preempt_resume();
    logic [3:0] rq [6];
    logic [3:0] dn [6];
    rq = '{4'b0100, 4'b0101, 4'b0101, 4'b1110, 4'b1110, 4'b0000};
    dn = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b1000};
    sb.push_back('{"pr_owner2", pk(4'b0100, 2'd1, 1'b0, 1'b0)});
    exp_pre = sat_inc(exp_pre);
    sb.push_back('{"pr_preempt", pk(4'b0001, 2'd2, 1'b1, 1'b0)});
    sb.push_back('{"pr_pulse_end", pk(4'b0001, 2'd2, 1'b0, 1'b0)});
    sb.push_back('{"pr_resume", pk(4'b0100, 2'd1, 1'b0, 1'b0)});
    sb.push_back('{"pr_rr_next", pk(4'b1000, 2'd1, 1'b0, 1'b0)});
    sb.push_back('{"pr_release", pk(4'b0000, 2'd0, 1'b0, 1'b0)});
    for (int i = 0; i < 6; i++) begin
      req  = rq[i];
      done = dn[i];
      tick();
      done = '0;
      e = sb.pop_front();
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
      end
    end
  endtask

  task automatic test_timeout();
    req = 4'b0010;
    sb.push_back('{"to_grant", pk(4'b0010, 2'd1, 1'b0, 1'b0)});
    for (int i = 1; i <= 15; i++) sb.push_back('{"to_hold", pk(4'b0010, 2'd1, 1'b0, 1'b0)});
    for (int i = 0; i <= 15; i++) begin
      tick();
      done = '0;
      req  = 4'b0110;
      e = sb.pop_front();
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL %s[%0d]: got %h expected %h", e.name, i, obs, e.v);
      end
      if (i == 4) done = 4'b0100;  // non-owner done must be ignored
    end
    exp_to = sat_inc(exp_to);
    sb.push_back('{"to_fire", pk(4'b0100, 2'd1, 1'b0, 1'b1)});
    sb.push_back('{"to_pulse_end", pk(4'b0100, 2'd1, 1'b0, 1'b0)});
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
      end
    end
    req  = '0;
    done = 4'b0100;
    sb.push_back('{"to_release", pk(4'b0000, 2'd0, 1'b0, 1'b0)});
    tick();
    done = '0;
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
    end
  endtask

  task automatic test_collision();
    logic [3:0] rq [4];
    logic [3:0] dn [4];
    rq = '{4'b1000, 4'b1001, 4'b1010, 4'b0000};
    dn = '{4'b0000, 4'b1000, 4'b0001, 4'b0010};
    sb.push_back('{"col_owner3", pk(4'b1000, 2'd1, 1'b0, 1'b0)});
    sb.push_back('{"col_done_req0", pk(4'b0001, 2'd2, 1'b0, 1'b0)});
    sb.push_back('{"col_no_save", pk(4'b0010, 2'd1, 1'b0, 1'b0)});
    sb.push_back('{"col_release", pk(4'b0000, 2'd0, 1'b0, 1'b0)});
    for (int i = 0; i < 4; i++) begin
      req  = rq[i];
      done = dn[i];
      tick();
      done = '0;
      e = sb.pop_front();
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
      end
    end
  endtask

  task automatic test_saturation_reset();
    req = 4'b0100;
    sb.push_back('{"sat_owner2", pk(4'b0100, 2'd1, 1'b0, 1'b0)});
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
    end
    for (int k = 0; k < 5; k++) begin
      req = 4'b0101;
      exp_pre = sat_inc(exp_pre);
      sb.push_back('{"sat_preempt", pk(4'b0001, 2'd2, 1'b1, 1'b0)});
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL %s[%0d]: got %h expected %h", e.name, k, obs, e.v);
      end
      if (k < 4) begin
        req  = 4'b0100;
        done = 4'b0001;
        sb.push_back('{"sat_resume", pk(4'b0100, 2'd1, 1'b0, 1'b0)});
        tick();
        done = '0;
        e = sb.pop_front();
        checks++;
        if (obs !== e.v) begin
          failures++;
          $display("FAIL %s[%0d]: got %h expected %h", e.name, k, obs, e.v);
        end
      end
    end
    #2;
    reset   = 1'b1;
    exp_pre = '0;
    exp_to  = '0;
    sb.push_back('{"rst_async_clear", pk(4'b0000, 2'd0, 1'b0, 1'b0)});
    sb.push_back('{"rst_held", pk(4'b0000, 2'd0, 1'b0, 1'b0)});
    sb.push_back('{"rst_no_resume", pk(4'b0010, 2'd1, 1'b0, 1'b0)});
    #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
    end
    req = 4'b0110;
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
    end
    reset = 1'b0;
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_round_robin();
    test_preempt_resume();
    test_timeout();
    test_collision();
    test_saturation_reset();
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
